// File: rtl/debouncer_multi_pkg.sv
// ============================================================================
// Module : debouncer_multi_pkg
// Brief  : Shared defaults and sizing helper for the multi-channel debouncer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debouncer_multi_pkg;

    localparam int DEB_TICK_DIV_DEF = 50000;
    localparam int DEB_STABLE_DEF   = 4;

    // One spare bit so STABLE_SAMPLES-1 always fits, including STABLE_SAMPLES=1.
    function automatic int deb_cnt_w(input int stable);
        return $clog2(stable) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_tick_gen.sv
// ============================================================================
// Module : debounce_tick_gen
// Brief  : Free-running prescaler; pulses sample_tick once every TICK_DIV clks.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_tick_gen
    import debouncer_multi_pkg::*;
#(
    parameter int TICK_DIV = DEB_TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_a_p,
    output logic sample_tick
);

    localparam int              CW     = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   c_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Decoded from the count so the tick is low throughout reset.
    assign sample_tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/debouncer_multi.sv
// ============================================================================
// Module : debouncer_multi
// Brief  : N-channel debouncer with shared sample tick and rise/fall pulses.
//          Define DEBOUNCE_SYNC_EN to add a 2-flop input synchroniser.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debouncer_multi
    import debouncer_multi_pkg::*;
#(
    parameter int   CHANNELS       = 4,
    parameter int   TICK_DIV       = DEB_TICK_DIV_DEF,
    parameter int   STABLE_SAMPLES = DEB_STABLE_DEF,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic                clk,
    input  logic                rst_a_p,
    input  logic [CHANNELS-1:0] db_in,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] db_rise,
    output logic [CHANNELS-1:0] db_fall,
    output logic                sample_tick
);

    localparam int               CNT_W      = deb_cnt_w(STABLE_SAMPLES);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic                w_tick;
    logic [CHANNELS-1:0] w_sample;

    debounce_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk         (clk),
        .rst_a_p     (rst_a_p),
        .sample_tick (w_tick)
    );

    assign sample_tick = w_tick;

`ifdef DEBOUNCE_SYNC_EN
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            r_sync1 <= {CHANNELS{RESET_LEVEL}};
            r_sync2 <= {CHANNELS{RESET_LEVEL}};
        end else begin
            r_sync1 <= db_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = db_in;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [CNT_W-1:0] r_cnt;
        logic             r_out;
        logic             r_rise;
        logic             r_fall;

        always_ff @(posedge clk or posedge rst_a_p) begin
            if (rst_a_p) begin
                r_cnt  <= '0;
                r_out  <= RESET_LEVEL;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (w_tick) begin
                    // Any sample matching the current level restarts the run.
                    if (w_sample[i] == r_out) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_out  <= w_sample[i];
                        r_cnt  <= '0;
                        r_rise <= w_sample[i];
                        r_fall <= ~w_sample[i];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end

        assign db_out[i]  = r_out;
        assign db_rise[i] = r_rise;
        assign db_fall[i] = r_fall;
    end

endmodule

`default_nettype wire

// File: tb/tb_debouncer_multi.sv
// ============================================================================
// Module : tb_debouncer_multi
// Brief  : Directed self-checking bench for debouncer_multi (2 ch, div 4, 3 samples).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debouncer_multi;

    localparam int CH = 2;
    localparam int TD = 4;
    localparam int SS = 3;

    logic          clk     = 1'b0;
    logic          rst_a_p = 1'b1;
    logic [CH-1:0] db_in   = '0;
    logic [CH-1:0] db_out;
    logic [CH-1:0] db_rise;
    logic [CH-1:0] db_fall;
    logic          sample_tick;

    int errors = 0;
    int checks = 0;

    debouncer_multi #(
        .CHANNELS       (CH),
        .TICK_DIV       (TD),
        .STABLE_SAMPLES (SS),
        .RESET_LEVEL    (1'b0)
    ) u_dut (
        .clk         (clk),
        .rst_a_p     (rst_a_p),
        .db_in       (db_in),
        .db_out      (db_out),
        .db_rise     (db_rise),
        .db_fall     (db_fall),
        .sample_tick (sample_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] o, input logic [1:0] r,
                            input logic [1:0] f);
        chk({tag, "_out"},  32'(db_out),  32'(o));
        chk({tag, "_rise"}, 32'(db_rise), 32'(r));
        chk({tag, "_fall"}, 32'(db_fall), 32'(f));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to the next tick cycle, then past the edge that consumes it.
    task automatic tt();
        int n;
        n = 0;
        while (!sample_tick && n < 2 * TD) begin
            step();
            n++;
        end
        chk("tick_seen", 32'(sample_tick), 32'd1);
        step();
    endtask

    initial begin
        rst_a_p = 1'b1;
        db_in   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset", 2'b00, 2'b00, 2'b00);
        chk("reset_tick", 32'(sample_tick), 32'd0);
        @(negedge clk);
        rst_a_p = 1'b0;

        // Idle: tick high in the 4th, 8th, ... cycle after release.
        for (int k = 1; k <= 40; k++) begin
            step();
            chk($sformatf("idle_tick_%0d", k), 32'(sample_tick), 32'((k % TD) == TD - 1));
            chk($sformatf("idle_out_%0d", k), 32'({db_out, db_rise, db_fall}), 32'd0);
        end

        // Channel 0 rises after three ticks sampling 1.
        db_in = 2'b01;
        tt(); chk_outs("s2_t1", 2'b00, 2'b00, 2'b00);
        tt(); chk_outs("s2_t2", 2'b00, 2'b00, 2'b00);
        tt(); chk_outs("s2_t3", 2'b01, 2'b01, 2'b00);
        step(); chk_outs("s2_after", 2'b01, 2'b00, 2'b00);

        // Channel 1 bounces 1,0,1 then holds.
        db_in = 2'b11; tt(); chk_outs("s3_b1", 2'b01, 2'b00, 2'b00);
        db_in = 2'b01; tt(); chk_outs("s3_b0", 2'b01, 2'b00, 2'b00);
        db_in = 2'b11; tt(); chk_outs("s3_h1", 2'b01, 2'b00, 2'b00);
        tt(); chk_outs("s3_h2", 2'b01, 2'b00, 2'b00);
        tt(); chk_outs("s3_h3", 2'b11, 2'b10, 2'b00);
        step(); chk_outs("s3_after", 2'b11, 2'b00, 2'b00);

        // Both channels fall together.
        db_in = 2'b00;
        tt(); chk_outs("s4_t1", 2'b11, 2'b00, 2'b00);
        tt(); chk_outs("s4_t2", 2'b11, 2'b00, 2'b00);
        tt(); chk_outs("s4_t3", 2'b00, 2'b00, 2'b11);
        step(); chk_outs("s4_after", 2'b00, 2'b00, 2'b00);

        // Re-establish 11, then reset with a partial fall in progress.
        db_in = 2'b11;
        tt(); tt(); tt(); chk_outs("s5_up", 2'b11, 2'b11, 2'b00);
        db_in = 2'b00;
        tt(); tt(); chk_outs("s5_mid", 2'b11, 2'b00, 2'b00);
        #3 rst_a_p = 1'b1;
        #1;
        chk_outs("s5_async", 2'b00, 2'b00, 2'b00);
        chk("s5_async_tick", 32'(sample_tick), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_a_p = 1'b0;
        db_in   = 2'b11;
        tt(); chk_outs("s5_r1", 2'b00, 2'b00, 2'b00);
        tt(); chk_outs("s5_r2", 2'b00, 2'b00, 2'b00);
        tt(); chk_outs("s5_r3", 2'b11, 2'b11, 2'b00);
        step(); chk_outs("s5_after", 2'b11, 2'b00, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
